// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes, burst FSM states,
// and a helper that classifies which operation codes may drive a burst.
// Purely declarative; no logic and no latency of its own.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SL   = 3'b001,
    MODE_SR   = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Only real shift/rotate codes may start a burst. Hold, load and the
  // reserved code produce a degenerate start instead.
  function automatic logic is_shift_mode(input mode_t m);
    case (m)
      MODE_SL, MODE_SR, MODE_ROL, MODE_ROR, MODE_ASR: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usr_shift_op.sv
// Next-value mux for the shift register: selects hold/shift/rotate/load result.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the caller decides whether to capture q_next.
// Ports: mode (operation), q (current value), parallel_in (load data),
//        serial_in_l / serial_in_r (fill bits), q_next (result).
module usr_shift_op
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SL:   q_next = {q[WIDTH-2:0], serial_in_l};
      MODE_SR:   q_next = {serial_in_r, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_LOAD: q_next = parallel_in;
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   q_next = q;  // hold and reserved code
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with clock enable and an N-step burst shift sequencer.
// Latency: single ops land 1 cycle after the edge; a burst takes count enabled cycles, done 1 cycle later.
// Backpressure: en=0 freezes all state and masks done; start is ignored while busy.
// Ports: clk/reset (sync, active-high), en, mode, parallel_in, serial_in_l/_r,
//        start/count (burst request), parallel_out, serial_out_msb/_lsb, busy, done.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  mode_t            bmode_q, bmode_d;
  logic [CW-1:0]    rem_q,   rem_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             done_q,  done_d;

  mode_t            mode_in;
  mode_t            op_mode;
  logic [WIDTH-1:0] q_next;

  assign mode_in = mode_t'(mode);

  // One mux serves both paths: during a burst the latched mode drives it,
  // otherwise the live mode input does.
  assign op_mode = (state_q == ST_SHIFT) ? bmode_q : mode_in;

  usr_shift_op #(
    .WIDTH (WIDTH)
  ) u_shift_op (
    .mode        (op_mode),
    .q           (q_q),
    .parallel_in (parallel_in),
    .serial_in_l (serial_in_l),
    .serial_in_r (serial_in_r),
    .q_next      (q_next)
  );

  always_comb begin
    state_d = state_q;
    bmode_d = bmode_q;
    rem_d   = rem_q;
    q_d     = q_q;
    done_d  = done_q;  // frozen while en=0
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Register is untouched in the start cycle either way.
            if (is_shift_mode(mode_in) && (count != '0)) begin
              state_d = ST_SHIFT;
              bmode_d = mode_in;
              rem_d   = count;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            q_d = q_next;
          end
        end
        ST_SHIFT: begin
          q_d   = q_next;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bmode_q <= MODE_HOLD;
      rem_q   <= '0;
      q_q     <= RESET_VAL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bmode_q <= bmode_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign parallel_out   = q_q;
  assign serial_out_msb = q_q[WIDTH-1];
  assign serial_out_lsb = q_q[0];
  assign busy           = (state_q == ST_SHIFT);
  // A pending done pulse stays stored across a stall but is only shown while enabled.
  assign done           = done_q & en;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): a byte-level
// arithmetic model tracks register value, remaining burst steps and done, and is
// compared every cycle; directed sequences add hand-computed literal checks.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset, en, start, sl, sr;
  logic [2:0] mode;
  logic [7:0] pin;
  logic [3:0] count;
  logic [7:0] po;
  logic       smsb, slsb, busy, done;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model state: value as an integer 0..255, shifts still owed by a burst,
  // the burst's operation, and a pending done pulse.
  int m_q = 0, m_left = 0, m_bmode = 0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .mode           (mode),
    .parallel_in    (pin),
    .serial_in_l    (sl),
    .serial_in_r    (sr),
    .start          (start),
    .count          (count),
    .parallel_out   (po),
    .serial_out_msb (smsb),
    .serial_out_lsb (slsb),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operation result expressed as byte arithmetic rather than bit slicing.
  function automatic int apply(int m, int v, int l, int r, int p);
    case (m)
      1:       return (v * 2 + l) % 256;
      2:       return v / 2 + r * 128;
      3:       return (v * 2) % 256 + v / 128;
      4:       return v / 2 + (v % 2) * 128;
      5:       return p;
      6:       return v / 2 + (v / 128) * 128;
      default: return v;
    endcase
  endfunction

  function automatic bit shift_code(int m);
    return (m == 1) || (m == 2) || (m == 3) || (m == 4) || (m == 6);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q = 0; m_left = 0; m_done = 1'b0;
    end else if (en) begin
      if (m_left > 0) begin
        m_q    = apply(m_bmode, m_q, int'(sl), int'(sr), int'(pin));
        m_left = m_left - 1;
        m_done = (m_left == 0);
      end else begin
        m_done = 1'b0;
        if (start) begin
          if (count != 0 && shift_code(int'(mode))) begin
            m_left  = int'(count);
            m_bmode = int'(mode);
          end else begin
            m_done = 1'b1;
          end
        end else begin
          m_q = apply(int'(mode), m_q, int'(sl), int'(sr), int'(pin));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_q",   32'(po),   32'(m_q));
      chk("model_msb", 32'(smsb), 32'(m_q / 128));
      chk("model_lsb", 32'(slsb), 32'(m_q % 2));
      chk("model_busy", 32'(busy), 32'(m_left > 0));
      chk("model_done", 32'(done), 32'(m_done & en));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'd5; pin = v; tick(); mode = 3'd0;
  endtask

  int n, nb;

  initial begin
    reset = 1'b1; en = 1'b1; start = 1'b0; sl = 1'b0; sr = 1'b0;
    mode = 3'd0; pin = 8'h00; count = 4'd0;
    tick(); tick();
    reset = 1'b0;
    chk_on = 1'b1;
    chk("reset_q", 32'(po), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Load and reset
    load(8'hA5);
    chk("load_a5", 32'(po), 32'hA5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset2_q", 32'(po), 32'h00);
    chk("reset2_busy", 32'(busy), 32'd0);
    chk("reset2_done", 32'(done), 32'd0);

    // Shifts
    load(8'h81); sl = 1'b1; mode = 3'd1; tick(); mode = 3'd0; sl = 1'b0;
    chk("sl_81", 32'(po), 32'h03);
    load(8'h81); sr = 1'b0; mode = 3'd2; tick(); mode = 3'd0;
    chk("sr_81", 32'(po), 32'h40);
    load(8'h80); mode = 3'd6; tick();
    chk("asr_80", 32'(po), 32'hC0);
    mode = 3'd7; tick(); tick(); mode = 3'd0;
    chk("rsvd_hold", 32'(po), 32'hC0);

    // Rotates
    load(8'h01); mode = 3'd4; tick(); mode = 3'd0;
    chk("ror_01", 32'(po), 32'h80);
    chk("ror_msb", 32'(smsb), 32'd1);
    load(8'hA5); mode = 3'd3;
    tick();
    chk("rol1_a5", 32'(po), 32'h4B);
    repeat (7) tick();
    mode = 3'd0;
    chk("rol8_a5", 32'(po), 32'hA5);

    // Burst with mode/parallel_in toggling while busy
    load(8'h0F); sl = 1'b0; mode = 3'd1; count = 4'd4; start = 1'b1; tick(); start = 1'b0;
    chk("burst_start_q", 32'(po), 32'h0F);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      mode = (n % 2 == 1) ? 3'd5 : 3'd2; pin = 8'hFF;
      tick();
    end
    mode = 3'd0;
    chk("burst_busy_cycles", 32'(n), 32'd4);
    chk("burst_q", 32'(po), 32'hF0);
    chk("burst_done", 32'(done), 32'd1);
    tick();
    chk("burst_done_once", 32'(done), 32'd0);
    chk("burst_q_after", 32'(po), 32'hF0);

    // Enable stall after the 2nd shift
    load(8'h0F); mode = 3'd1; count = 4'd4; start = 1'b1; tick(); start = 1'b0; mode = 3'd0;
    nb = (busy === 1'b1) ? 1 : 0;
    tick(); if (busy === 1'b1) nb++;
    tick(); if (busy === 1'b1) nb++;
    chk("stall_pre_q", 32'(po), 32'h3C);
    en = 1'b0;
    repeat (3) begin
      tick();
      if (busy === 1'b1) nb++;
      chk("stall_q", 32'(po), 32'h3C);
      chk("stall_done", 32'(done), 32'd0);
    end
    en = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++; tick();
      if (busy === 1'b1) nb++;
    end
    chk("stall_busy_span", 32'(nb), 32'd7);
    chk("stall_q_final", 32'(po), 32'hF0);
    chk("stall_done", 32'(done), 32'd1);
    tick();

    // Reset mid-burst
    load(8'h0F); mode = 3'd1; count = 4'd4; start = 1'b1; tick(); start = 1'b0; mode = 3'd0;
    tick(); tick();
    chk("midrst_pre", 32'(po), 32'h3C);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_q", 32'(po), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    tick();
    chk("midrst_no_done", 32'(done), 32'd0);

    // Degenerate starts: zero count, then a non-shift mode
    load(8'h5A); mode = 3'd1; count = 4'd0; start = 1'b1; tick(); start = 1'b0; mode = 3'd0;
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd0);
    chk("cnt0_q", 32'(po), 32'h5A);
    tick();
    chk("cnt0_done_once", 32'(done), 32'd0);
    mode = 3'd5; pin = 8'h33; count = 4'd3; start = 1'b1; tick(); start = 1'b0; mode = 3'd0;
    chk("loadstart_done", 32'(done), 32'd1);
    chk("loadstart_q", 32'(po), 32'h5A);
    tick();

    // Back-to-back bursts: new start in the done cycle
    load(8'h0F); mode = 3'd1; count = 4'd1; start = 1'b1; tick(); start = 1'b0; mode = 3'd0;
    chk("b2b_busy1", 32'(busy), 32'd1);
    tick();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_q1", 32'(po), 32'h1E);
    mode = 3'd3; count = 4'd2; start = 1'b1; tick(); start = 1'b0; mode = 3'd0;
    chk("b2b_busy2", 32'(busy), 32'd1);
    chk("b2b_nodone", 32'(done), 32'd0);
    tick(); tick();
    chk("b2b_q2", 32'(po), 32'h78);
    chk("b2b_done2", 32'(done), 32'd1);

    // Burst longer than the width: 10 right rotates of 0x01 equal 2 rotates
    load(8'h01); mode = 3'd4; count = 4'd10; start = 1'b1; tick(); start = 1'b0; mode = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; tick(); end
    chk("long_busy", 32'(n), 32'd10);
    chk("long_q", 32'(po), 32'h40);
    tick();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 4-bit PIPO register. It adds the following to parallel load:
- shift-left and shift-right, logical and arithmetic
- rotate-left and rotate-right
- a clock enable
- an autonomous burst-shift sequencer that applies a chosen shift/rotate N times with a busy/done handshake.

It serves as the general register/serialiser primitive for datapath and serial-link blocks.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, {WIDTH{1'b0}}, value of parallel_out after reset.
- CW, $clog2(WIDTH+1), burst count width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  clock enable; 0 freezes all state
- mode  in  3  operation select (codes below)
- parallel_in  in  WIDTH  load data
- serial_in_l  in  1  bit shifted into LSB on shift-left
- serial_in_r  in  1  bit shifted into MSB on logical shift-right
- start  in  1  begin burst using current mode and count
- count  in  CW  number of burst shifts
- parallel_out  out  WIDTH  register contents
- serial_out_msb  out  1  parallel_out[WIDTH-1], combinational
- serial_out_lsb  out  1  parallel_out[0], combinational
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset: parallel_out=RESET_VAL, busy=0, done=0, FSM=IDLE, remaining count=0. Reset overrides all other inputs.
- Mode codes, each applied on the clock edge:
  - 000 hold
  - 001 SL: {q[W-2:0],serial_in_l}
  - 010 SR: {serial_in_r,q[W-1:1]}
  - 011 ROL: {q[W-2:0],q[W-1]}
  - 100 ROR: {q[0],q[W-1:1]}
  - 101 LOAD: parallel_in
  - 110 ASR: {q[W-1],q[W-1:1]}
  - 111 reserved, behaves as hold
- Single-cycle ops: in IDLE with en=1 and start=0, the mode op is applied at the next edge. Latency is 1 cycle.
- en=0: register, FSM, remaining count and done are all frozen. done is driven 0 while en=0. start is ignored.
- FSM states:
  - IDLE to SHIFT: start=1, en=1, count!=0, and mode in {001,010,011,100,110}. Latches mode to bmode and count to rem. The register is unchanged in the start cycle.
  - IDLE degenerate start: start=1, en=1, and count==0 or mode not a shift code. No register change, stays IDLE, done=1 the next cycle, busy never asserts.
  - SHIFT: on each en=1 cycle, apply bmode and decrement rem. When rem==1, go to IDLE and assert done (registered) for the following cycle.
- Serial inputs are sampled live every shift cycle during a burst.
- busy=1 exactly while the FSM is in SHIFT. It is high for count enabled cycles.
- During SHIFT, mode, parallel_in and start are ignored.
- Back-to-back bursts: start is accepted in the cycle done is high. The FSM is IDLE in that cycle.
- Reset mid-burst: the FSM returns to IDLE and parallel_out=RESET_VAL. No done pulse is produced.
- count may exceed WIDTH. The burst simply performs count shifts; rotates wrap modulo WIDTH.
- Priority: reset > active burst > start > mode.

Decomposition:
- Package usr_pkg holds:
  - mode enum: MODE_HOLD, MODE_SL, MODE_SR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_ASR, MODE_RSVD
  - FSM state enum: ST_IDLE, ST_SHIFT
  - function is_shift_mode()
- One natural sub-module, usr_shift_op: combinational next-value mux (q, mode, serial ins, parallel_in to q_next). It is shared by the single-op and burst paths.

Test Plan (WIDTH=8, RESET_VAL=0):
- Load and reset: mode=101, parallel_in=0xA5, en=1 gives 0xA5 after 1 edge. Asserting reset for 1 cycle then gives 0x00, busy=0, done=0.
- Shifts:
  - From 0x81, SL with serial_in_l=1 gives 0x03.
  - From 0x81, SR with serial_in_r=0 gives 0x40.
  - From 0x80, ASR gives 0xC0.
  - Mode 111 holds.
- Rotates:
  - From 0x01, ROR gives 0x80.
  - From 0xA5, 8 consecutive ROL cycles return 0xA5.
  - serial_out_msb and serial_out_lsb track bits 7 and 0 each cycle.
- Burst:
  - Setup: load 0x0F, then start with mode=001, count=4, serial_in_l=0.
  - busy is high 4 cycles and the final value is 0xF0.
  - done is high exactly 1 cycle after the last shift.
  - Toggling mode/parallel_in during busy has no effect.
- Enable stall:
  - In the same burst, drop en for 3 cycles after the 2nd shift. The register, busy and rem are frozen and done stays 0.
  - Total shifts are still 4 (result 0xF0), and busy spans 7 cycles.
- Edge cases:
  - reset after 2 shifts of a burst gives 0x00, busy=0 and no done pulse.
  - start with count=0 gives done the next cycle, busy never high, register unchanged.
  - start in the done cycle launches a new burst.
